conv_stage_mc: RTL and testbench

Multi-cycle, time-multiplexed convolution stage. It accepts one NxN pixel window per handshake into a small FIFO. It evaluates NumberOfK kernels on each window using ProcessingElements parallel dot-product lanes over CyclesPerPixel output beats. Kernels are runtime-loadable, arithmetic is signed with saturation and optional ReLU, and both sides use valid/ready handshakes. It sits between the window generator and the pooling/next convolution stage.

---
 rtl/conv_stage_mc.sv | 209 ++++++++++++++++++++
 tb/tb_conv_stage_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stage_mc.sv
// conv_stage_mc: time-multiplexed NxN convolution stage.
// Windows queue in a small FIFO; each window produces CyclesPerPixel output
// beats, with ProcessingElements kernels evaluated in parallel per beat.
// Results are saturated to BitSize and optionally clamped at zero (Relu).
module conv_stage_mc #(
  parameter int NumberOfK          = 4,
  parameter int N                  = 3,
  parameter int BitSize            = 16,
  parameter int KernelBitSize      = 4,
  parameter int CyclesPerPixel     = 2,
  parameter int ProcessingElements = (NumberOfK + CyclesPerPixel - 1) / CyclesPerPixel,
  parameter int FifoDepth          = 4,
  parameter bit Relu               = 1'b0,
  localparam int KAW = (NumberOfK > 1) ? $clog2(NumberOfK) : 1,
  localparam int GW  = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1
) (
  input  logic                                clk,
  input  logic                                res,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N*N*BitSize-1:0]              in_data,
  input  logic                                k_we,
  input  logic [KAW-1:0]                      k_addr,
  input  logic [N*N*KernelBitSize-1:0]        k_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ProcessingElements*BitSize-1:0] out_data,
  output logic [GW-1:0]                       out_group,
  output logic                                out_last
);

  localparam int E   = N * N;
  localparam int WW  = E * BitSize;
  localparam int KW  = E * KernelBitSize;
  localparam int OW  = ProcessingElements * BitSize;
  localparam int AW  = BitSize + KernelBitSize + $clog2(E);
  localparam int PW  = $clog2(FifoDepth);
  localparam int CW  = PW + 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BitSize+1){1'b0}}, {(BitSize-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BitSize+1){1'b1}}, {(BitSize-1){1'b0}}};
  localparam logic [GW-1:0]        G_LAST  = GW'(CyclesPerPixel - 1);

  logic [WW-1:0] fifo_mem_q [FifoDepth];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [GW-1:0] g_q;
  logic [GW-1:0] g_d;
  logic [KW-1:0] kern_q [NumberOfK];

  logic          out_valid_q;
  logic          out_valid_d;
  logic [OW-1:0] out_data_q;
  logic [OW-1:0] out_data_d;
  logic [GW-1:0] out_group_q;
  logic [GW-1:0] out_group_d;
  logic          out_last_q;
  logic          out_last_d;

  logic          push_s;
  logic          pop_s;
  logic          load_s;
  logic          fifo_empty_s;
  logic          g_last_s;
  logic [WW-1:0] head_s;
  logic [OW-1:0] lanes_s;

  // Acceptance depends only on the registered occupancy; no same-cycle bypass.
  assign in_ready     = (count_q < CW'(FifoDepth));
  assign push_s       = in_valid && in_ready;
  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign load_s       = !fifo_empty_s && (!out_valid_q || out_ready);
  assign g_last_s     = (g_q == G_LAST);
  assign pop_s        = load_s && g_last_s;
  assign head_s       = fifo_mem_q[rd_ptr_q];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_group = out_group_q;
  assign out_last  = out_last_q;

  // Dot products of the FIFO head against the kernels selected by the current beat.
  always_comb begin
    logic signed [BitSize-1:0]               px;
    logic signed [KernelBitSize-1:0]         wt;
    logic signed [BitSize+KernelBitSize-1:0] prod;
    logic signed [AW-1:0]                    acc;
    logic [KW-1:0]                           ksel;
    logic                                    sel_hit;
    logic [BitSize-1:0]                      lane_v;
    int                                      kidx;
    lanes_s = {OW{1'b0}};
    px      = {BitSize{1'b0}};
    wt      = {KernelBitSize{1'b0}};
    prod    = {(BitSize+KernelBitSize){1'b0}};
    acc     = {AW{1'b0}};
    ksel    = {KW{1'b0}};
    sel_hit = 1'b0;
    lane_v  = {BitSize{1'b0}};
    kidx    = 0;
    for (int p = 0; p < ProcessingElements; p++) begin
      kidx    = int'(g_q) * ProcessingElements + p;
      ksel    = {KW{1'b0}};
      sel_hit = 1'b0;
      // Lanes mapped past the last kernel find no match and emit zero.
      for (int k = 0; k < NumberOfK; k++) begin
        ksel    = (kidx == k) ? kern_q[k] : ksel;
        sel_hit = (kidx == k) ? 1'b1 : sel_hit;
      end
      acc = {AW{1'b0}};
      for (int e = 0; e < E; e++) begin
        px   = head_s[e*BitSize +: BitSize];
        wt   = ksel[e*KernelBitSize +: KernelBitSize];
        prod = px * wt;
        acc  = acc + AW'(prod);
      end
      if (acc > SAT_MAX) begin
        lane_v = SAT_MAX[BitSize-1:0];
      end else if (acc < SAT_MIN) begin
        lane_v = SAT_MIN[BitSize-1:0];
      end else begin
        lane_v = acc[BitSize-1:0];
      end
      if (Relu && lane_v[BitSize-1]) begin
        lane_v = {BitSize{1'b0}};
      end else begin
        lane_v = lane_v;
      end
      lanes_s[p*BitSize +: BitSize] = sel_hit ? lane_v : {BitSize{1'b0}};
    end
  end

  // Next-state for occupancy, beat counter and the output beat register.
  always_comb begin
    count_d     = count_q;
    g_d         = g_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_group_d = out_group_q;
    out_last_d  = out_last_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = lanes_s;
      out_group_d = g_q;
      out_last_d  = g_last_s;
      g_d         = g_last_s ? {GW{1'b0}} : (g_q + GW'(1));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output registers; reset drops queued windows and the pending beat.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      g_q         <= {GW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OW{1'b0}};
      out_group_q <= {GW{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_q    <= pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      count_q     <= count_d;
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_group_q <= out_group_d;
      out_last_q  <= out_last_d;
    end
  end

  // Window storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Kernel registers; out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int k = 0; k < NumberOfK; k++) begin
        kern_q[k] <= {KW{1'b0}};
      end
    end else begin
      for (int k = 0; k < NumberOfK; k++) begin
        if (k_we && (k_addr == KAW'(k))) begin
          kern_q[k] <= k_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_stage_mc.sv
// Bench for conv_stage_mc: three instances (default, Relu=1, NumberOfK=3)
// driven in lockstep; expected beats are queued on accepted pushes.
module tb_conv_stage_mc;

  logic          clk;
  logic          res;
  logic          in_valid;
  logic [143:0]  in_data;
  logic          k_we;
  logic [1:0]    k_addr;
  logic [35:0]   k_data;
  logic          out_ready;
  logic [2:0]    ir;
  logic [2:0]    ov;
  logic [2:0]    og;
  logic [2:0]    ol;
  logic [31:0]   od0;
  logic [31:0]   od1;
  logic [31:0]   od2;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        g;
    logic        l;
  } beat_t;

  beat_t sbq[$];
  int    mw[9];
  int    kw[9];
  int    mk[4][9];
  int    passed = 0;
  int    total  = 0;
  int    beats  = 0;

  conv_stage_mc u_def (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .k_we(k_we), .k_addr(k_addr), .k_data(k_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od0), .out_group(og[0]), .out_last(ol[0])
  );

  conv_stage_mc #(.Relu(1'b1)) u_relu (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .k_we(k_we), .k_addr(k_addr), .k_data(k_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od1), .out_group(og[1]), .out_last(ol[1])
  );

  conv_stage_mc #(.NumberOfK(3)) u_k3 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .k_we(k_we), .k_addr(k_addr), .k_data(k_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od2), .out_group(og[2]), .out_last(ol[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic logic [15:0] model_lane(int k, int nk, bit relu);
    longint acc;
    acc = 0;
    if (k >= nk) return 16'h0000;
    for (int e = 0; e < 9; e++) acc += longint'(mw[e]) * longint'(mk[k][e]);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc[15:0];
  endfunction

  function automatic logic [143:0] pack_win();
    logic [143:0] v;
    v = 144'd0;
    for (int e = 0; e < 9; e++) v[e*16 +: 16] = mw[e][15:0];
    return v;
  endfunction

  function automatic logic [35:0] pack_ker();
    logic [35:0] v;
    v = 36'd0;
    for (int e = 0; e < 9; e++) v[e*4 +: 4] = kw[e][3:0];
    return v;
  endfunction

  task automatic check(string tag, logic [95:0] got, logic [95:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock: score the beat handed over at this edge, queue expectations
  // for an accepted window, track kernel writes, then advance past the edge.
  task automatic cycle();
    beat_t e;
    bit pushed;
    bit consumed;
    pushed   = !res && in_valid && ir[0];
    consumed = !res && ov[0] && out_ready;
    if (consumed) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_beat", ov, 96'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_data", {od0, od1, od2}, {e.d0, e.d1, e.d2});
        check("sb_tag", {og, ol}, {{3{e.g}}, {3{e.l}}});
        check("sb_valid_all", ov, 96'd7);
        beats++;
      end
    end
    if (pushed) begin
      for (int g = 0; g < 2; g++) begin
        e.d0 = {model_lane(2*g+1, 4, 1'b0), model_lane(2*g, 4, 1'b0)};
        e.d1 = {model_lane(2*g+1, 4, 1'b1), model_lane(2*g, 4, 1'b1)};
        e.d2 = {model_lane(2*g+1, 3, 1'b0), model_lane(2*g, 3, 1'b0)};
        e.g  = g[0];
        e.l  = (g == 1);
        sbq.push_back(e);
      end
    end
    if (!res && k_we) begin
      for (int i = 0; i < 9; i++) mk[int'(k_addr)][i] = kw[i];
    end
    @(posedge clk);
    #1;
    if (res) begin
      sbq.delete();
      for (int k = 0; k < 4; k++) for (int i = 0; i < 9; i++) mk[k][i] = 0;
    end
  endtask

  task automatic drain(int max_cycles);
    int n;
    n = 0;
    while ((sbq.size() != 0 || ov != 3'b000) && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_queue", sbq.size(), 96'd0);
    check("drain_valid", ov, 96'd0);
  endtask

  task automatic load_kernel(int addr);
    k_addr = addr[1:0];
    k_data = pack_ker();
    k_we   = 1'b1;
    cycle();
    k_we   = 1'b0;
  endtask

  task automatic set_window(int v);
    for (int e = 0; e < 9; e++) mw[e] = v;
    in_data = pack_win();
  endtask

  task automatic push_one();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    beat_t f;
    res = 1'b1; in_valid = 1'b0; in_data = 144'd0; k_we = 1'b0;
    k_addr = 2'd0; k_data = 36'd0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) for (int i = 0; i < 9; i++) mk[k][i] = 0;
    for (int i = 0; i < 9; i++) begin mw[i] = 0; kw[i] = 0; end
    #2;
    cycle();
    cycle();
    res = 1'b0;
    check("rst_valid", ov, 96'd0);
    check("rst_data", {od0, od1, od2}, 96'd0);
    check("rst_tag", {og, ol}, 96'd0);
    check("rst_ready", ir, 96'd7);

    // Kernels: k0 all 1, k1 all 2, k2 all -1, k3 centre 1.
    for (int i = 0; i < 9; i++) kw[i] = 1;
    load_kernel(0);
    for (int i = 0; i < 9; i++) kw[i] = 2;
    load_kernel(1);
    for (int i = 0; i < 9; i++) kw[i] = -1;
    load_kernel(2);
    for (int i = 0; i < 9; i++) kw[i] = (i == 4) ? 1 : 0;
    load_kernel(3);

    // Basic window of 3s; beat 0 appears one cycle after the push edge.
    set_window(3);
    push_one();
    check("lat_not_yet", ov, 96'd0);
    cycle();
    check("beat0_valid", ov, 96'd7);
    check("beat0_def", od0, {16'd54, 16'd27});
    check("beat0_tag", {og[0], ol[0]}, 96'd0);
    cycle();
    check("beat1_def", od0, {16'd3, 16'hFFE5});
    check("beat1_relu", od1, {16'd3, 16'd0});
    check("beat1_k3", od2, {16'd0, 16'hFFE5});
    check("beat1_tag", {og[0], ol[0]}, 96'd3);
    cycle();
    check("idle_after", ov, 96'd0);

    // Saturation with k0 all 7.
    for (int i = 0; i < 9; i++) kw[i] = 7;
    load_kernel(0);
    set_window(32767);
    push_one();
    cycle();
    check("sat_pos", od0[15:0], 96'h7FFF);
    drain(10);
    set_window(-32768);
    push_one();
    cycle();
    check("sat_neg", od0[15:0], 96'h8000);
    drain(10);

    // Backpressure: five offers, four accepted.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int e = 0; e < 9; e++) mw[e] = int'($urandom_range(0, 65535)) - 32768;
      in_data  = pack_win();
      in_valid = 1'b1;
      check("bp_ready", ir, (i < 4) ? 96'd7 : 96'd0);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f = sbq[0];
      check("bp_hold_data", {od0, od1, od2}, {f.d0, f.d1, f.d2});
      check("bp_hold_tag", {og, ol, ov}, {3'b000, 3'b000, 3'b111});
      cycle();
    end
    out_ready = 1'b1;
    beats = 0;
    cycle();
    check("bp_ready_back", ir, 96'd7);
    drain(30);
    check("bp_beat_count", beats, 96'd8);

    // Write to k_addr 3: real for 4-kernel instances, no effect for NumberOfK=3.
    for (int i = 0; i < 9; i++) kw[i] = 7;
    load_kernel(3);
    set_window(1);
    push_one();
    cycle();
    cycle();
    check("k3_lane1_zero", od2[31:16], 96'd0);
    check("def_k3_written", od0[31:16], 96'd63);
    drain(10);

    // Reset mid-stream after two beats have been delivered.
    set_window(2);
    in_valid = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    res = 1'b1;
    cycle();
    res = 1'b0;
    check("mid_rst_valid", ov, 96'd0);
    check("mid_rst_ready", ir, 96'd7);
    set_window(5);
    push_one();
    cycle();
    check("post_rst_valid", ov, 96'd7);
    check("post_rst_zero", {od0, od1, od2}, 96'd0);
    drain(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
